// File: rtl/mini_soc_pkg.sv
// mini_soc_pkg: shared constants, opcode encoding and ALU helper for the
// mini_soc_top microcontroller slice.
//   - width constants for fetch address, instruction, data and output port
//   - opcode_t: 4-bit instruction opcodes
//   - timer register indices and the CTRL enable bit position
//   - alu_calc: 8-bit modulo arithmetic/logic used by the CPU datapath
package mini_soc_pkg;

  localparam int PC_WIDTH   = 7;
  localparam int INS_WIDTH  = 16;
  localparam int DATA_WIDTH = 8;
  localparam int PORT_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_OUT  = 4'h8,
    OP_STT  = 4'h9,
    OP_LDT  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JNZ  = 4'hD,
    OP_ADDI = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  localparam logic [1:0] TMR_COUNT  = 2'd0;
  localparam logic [1:0] TMR_STATUS = 2'd1;
  localparam logic [1:0] TMR_CTRL   = 2'd2;
  localparam logic [1:0] TMR_PERIOD = 2'd3;

  localparam int CTRL_EN_BIT = 7;

  // ADDI shares the adder with ADD; caller selects imm8 as operand b.
  function automatic logic [DATA_WIDTH-1:0] alu_calc(
    input opcode_t                 op,
    input logic [DATA_WIDTH-1:0]   a,
    input logic [DATA_WIDTH-1:0]   b
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    case (op)
      OP_ADD, OP_ADDI: res = a + b;
      OP_SUB:          res = a - b;
      OP_AND:          res = a & b;
      OP_OR:           res = a | b;
      OP_XOR:          res = a ^ b;
      default:         res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/soc_timer.sv
// soc_timer: four 8-bit memory-mapped timer registers tmr_reg[0:3].
//   [0] COUNT  (CPU read-only), [1] STATUS/scratch, [2] CTRL (bit7 enable),
//   [3] PERIOD.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   wr_en  in   CPU write strobe
//   addr   in   register index for write and read
//   wdata  in   write data
//   rdata  out  combinational read of tmr_reg[addr]
// Build option MINI_SOC_MATCH_FLAG_EN: STATUS bit0 becomes a sticky match
// flag (set on enabled match, cleared by any write, set wins); bits 7:1 read 0.
// Otherwise STATUS is a plain read/write scratch register.
module soc_timer
  import mini_soc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] tmr_reg [0:3];
  logic                  w_match;
  logic                  w_en;

  assign w_match = (tmr_reg[TMR_COUNT] == tmr_reg[TMR_PERIOD]);
  assign w_en    = tmr_reg[TMR_CTRL][CTRL_EN_BIT];
  assign rdata   = tmr_reg[addr];

  // Counting uses pre-edge CTRL/PERIOD, so a write on this edge only
  // affects counting from the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_reg <= '{default: '0};
    end else begin
      if (w_match) begin
        tmr_reg[TMR_COUNT] <= '0;
      end else if (w_en) begin
        tmr_reg[TMR_COUNT] <= tmr_reg[TMR_COUNT] + 1'b1;
      end

`ifdef MINI_SOC_MATCH_FLAG_EN
      if (w_match && w_en) begin
        tmr_reg[TMR_STATUS] <= 8'h01;
      end else if (wr_en && (addr == TMR_STATUS)) begin
        tmr_reg[TMR_STATUS] <= '0;
      end
`else
      if (wr_en && (addr == TMR_STATUS)) begin
        tmr_reg[TMR_STATUS] <= wdata;
      end
`endif

      if (wr_en && (addr == TMR_CTRL)) begin
        tmr_reg[TMR_CTRL] <= wdata;
      end
      if (wr_en && (addr == TMR_PERIOD)) begin
        tmr_reg[TMR_PERIOD] <= wdata;
      end
    end
  end

endmodule

// File: rtl/mini_soc_top.sv
// mini_soc_top: 8-bit accumulator-style CPU with four registers, a
// memory-mapped timer (instance `timer`) and a 4-bit output port.
// Ports:
//   clk      in   system clock, all state on rising edge
//   rst      in   asynchronous active-high reset
//   ins_out  in   instruction word for the pc presented the previous cycle
//   pc       out  instruction fetch address (external 128 x 16 memory)
//   porta    out  general-purpose output port, written by OUT
// Build option MINI_SOC_MATCH_FLAG_EN is consumed by soc_timer.
module mini_soc_top
  import mini_soc_pkg::*;
#(
  parameter int PC_W   = PC_WIDTH,
  parameter int INS_W  = INS_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int PORT_W = PORT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INS_W-1:0]  ins_out,
  output logic [PC_W-1:0]   pc,
  output logic [PORT_W-1:0] porta
);

  logic [PC_W-1:0]   r_pc;
  logic              r_valid;
  logic              r_halted;
  logic              r_z;
  logic [PORT_W-1:0] r_porta;
  logic [DATA_W-1:0] r_regs [0:3];

  opcode_t           w_op;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs;
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_tgt;
  logic              w_exec;

  logic [DATA_W-1:0] w_result;
  logic              w_wr_rd;
  logic              w_upd_z;
  logic              w_jump;
  logic              w_halt;
  logic              w_out;
  logic              w_stt;
  logic [DATA_W-1:0] w_tmr_rdata;

  assign w_op   = opcode_t'(ins_out[15:12]);
  assign w_rd   = ins_out[11:10];
  assign w_rs   = ins_out[9:8];
  assign w_imm  = ins_out[7:0];
  assign w_tgt  = ins_out[PC_W-1:0];
  // Squashed or post-halt words behave as NOP.
  assign w_exec = r_valid && !r_halted;

  assign pc    = r_pc;
  assign porta = r_porta;

  soc_timer timer (
    .clk   (clk),
    .rst   (rst),
    .wr_en (w_stt),
    .addr  (w_rs),
    .wdata (r_regs[w_rd]),
    .rdata (w_tmr_rdata)
  );

  always_comb begin
    w_result = '0;
    w_wr_rd  = 1'b0;
    w_upd_z  = 1'b0;
    w_jump   = 1'b0;
    w_halt   = 1'b0;
    w_out    = 1'b0;
    w_stt    = 1'b0;
    if (w_exec) begin
      case (w_op)
        OP_LDI: begin
          w_result = w_imm;
          w_wr_rd  = 1'b1;
        end
        OP_MOV: begin
          w_result = r_regs[w_rs];
          w_wr_rd  = 1'b1;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          w_result = alu_calc(w_op, r_regs[w_rd], r_regs[w_rs]);
          w_wr_rd  = 1'b1;
          w_upd_z  = 1'b1;
        end
        OP_ADDI: begin
          w_result = alu_calc(w_op, r_regs[w_rd], w_imm);
          w_wr_rd  = 1'b1;
          w_upd_z  = 1'b1;
        end
        OP_LDT: begin
          w_result = w_tmr_rdata;
          w_wr_rd  = 1'b1;
          w_upd_z  = 1'b1;
        end
        OP_OUT:  w_out  = 1'b1;
        OP_STT:  w_stt  = 1'b1;
        OP_JMP:  w_jump = 1'b1;
        OP_JZ:   w_jump = r_z;
        OP_JNZ:  w_jump = !r_z;
        OP_HALT: w_halt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_z      <= 1'b0;
      r_porta  <= '0;
      r_regs   <= '{default: '0};
    end else begin
      // pc freezes on the HALT edge itself, so it holds the address after HALT.
      if (!(r_halted || w_halt)) begin
        r_pc <= w_jump ? w_tgt : r_pc + 1'b1;
      end
      // The word arriving after a taken jump was fetched sequentially.
      r_valid  <= !w_jump;
      r_halted <= r_halted | w_halt;
      if (w_wr_rd) begin
        r_regs[w_rd] <= w_result;
      end
      if (w_upd_z) begin
        r_z <= (w_result == '0);
      end
      if (w_out) begin
        r_porta <= r_regs[w_rs][PORT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mini_soc_top.sv
module tb_mini_soc_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ins_out = '0;
  logic [6:0]  pc;
  logic [3:0]  porta;

  logic [15:0] mem [0:127];
  int          n_pass   = 0;
  int          n_checks = 0;
  int          cyc      = 0;
  logic [7:0]  exp_cnt [0:13];

  mini_soc_top #(
    .PC_W   (7),
    .INS_W  (16),
    .DATA_W (8),
    .PORT_W (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ins_out (ins_out),
    .pc      (pc),
    .porta   (porta)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory.
  always @(posedge clk) ins_out <= mem[pc];

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic load_begin();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_rst();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    // ---------------- reset, fetch start, squash of first word, timer count
    load_begin();
    mem[0] = 16'hE001;  // ADDI R0,1 (doubled if first word not squashed)
    mem[1] = 16'h8000;  // OUT R0
    mem[2] = 16'h1005;  // LDI R0,5
    mem[3] = 16'h9300;  // STT 3,R0
    mem[4] = 16'h1480;  // LDI R1,0x80
    mem[5] = 16'h9600;  // STT 2,R1
    release_rst();
    chk("rst_pc", pc, 0);
    chk("rst_porta", porta, 0);
    chk("rst_tmr0", dut.timer.tmr_reg[0], 0);
    chk("rst_tmr1", dut.timer.tmr_reg[1], 0);
    chk("rst_tmr2", dut.timer.tmr_reg[2], 0);
    chk("rst_tmr3", dut.timer.tmr_reg[3], 0);
    to_cycle(1); chk("pc_c1", pc, 1);
    to_cycle(2); chk("pc_c2", pc, 2);
    to_cycle(3); chk("pc_c3", pc, 3);
    chk("squash_porta", porta, 1);
    exp_cnt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0,
                8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    to_cycle(7);
    chk("ctrl_en", dut.timer.tmr_reg[2], 8'h80);
    chk("period5", dut.timer.tmr_reg[3], 8'd5);
    for (int k = 0; k < 14; k++) begin
      to_cycle(7 + k);
      chk("count_p5", dut.timer.tmr_reg[0], exp_cnt[k]);
    end

    // ---------------- timer disabled, COUNT write ignored, STATUS access
    load_begin();
    mem[0] = 16'h1009;  // LDI R0,9
    mem[1] = 16'h9300;  // STT 3,R0
    mem[2] = 16'h1407;  // LDI R1,7
    mem[3] = 16'h9400;  // STT 0,R1 (ignored)
    mem[4] = 16'h9500;  // STT 1,R1
    mem[5] = 16'hAD00;  // LDT R3,1
    mem[6] = 16'h8300;  // OUT R3
    release_rst();
    to_cycle(4);
    chk("period9", dut.timer.tmr_reg[3], 8'd9);
    to_cycle(6);
`ifdef MINI_SOC_MATCH_FLAG_EN
    chk("status_wr", dut.timer.tmr_reg[1], 8'h00);
    to_cycle(8);
    chk("status_ldt_out", porta, 4'h0);
`else
    chk("status_wr", dut.timer.tmr_reg[1], 8'h07);
    to_cycle(8);
    chk("status_ldt_out", porta, 4'h7);
`endif
    for (int k = 5; k < 16; k += 2) begin
      to_cycle(k);
      chk("count_disabled", dut.timer.tmr_reg[0], 0);
    end

    // ---------------- Z flag, JZ not taken / taken, squash slot, pc wrap
    load_begin();
    mem[0]    = 16'h180F;  // LDI R2,0x0F
    mem[1]    = 16'hE801;  // ADDI R2,1 -> 0x10, Z=0
    mem[2]    = 16'hC020;  // JZ 0x20 (not taken)
    mem[3]    = 16'h8200;  // OUT R2 -> 0
    mem[4]    = 16'h1CFF;  // LDI R3,0xFF
    mem[5]    = 16'hEC01;  // ADDI R3,1 -> 0, Z=1
    mem[6]    = 16'hC040;  // JZ 0x40 (taken)
    mem[7]    = 16'h1033;  // LDI R0,0x33 (squashed)
    mem[7'h40] = 16'hE002; // ADDI R0,2
    mem[7'h41] = 16'h8000; // OUT R0
    mem[7'h42] = 16'hB07F; // JMP 0x7F
    release_rst();
    to_cycle(5);
    chk("jz_not_taken_pc", pc, 5);
    chk("out_r2_porta", porta, 0);
    to_cycle(8); chk("jz_taken_pc", pc, 7'h40);
    to_cycle(9); chk("jz_next_pc", pc, 7'h41);
    to_cycle(11); chk("jump_squash_porta", porta, 2);
    to_cycle(12); chk("jmp_7f_pc", pc, 7'h7F);
    to_cycle(13); chk("pc_wrap", pc, 0);

    // ---------------- HALT with timer still running, async reset mid-run
    load_begin();
    mem[0]  = 16'h1003;  // LDI R0,3
    mem[1]  = 16'h9300;  // STT 3,R0
    mem[2]  = 16'h1480;  // LDI R1,0x80
    mem[3]  = 16'h9600;  // STT 2,R1
    mem[4]  = 16'h180A;  // LDI R2,0x0A
    mem[5]  = 16'h8200;  // OUT R2
    mem[10] = 16'hF000;  // HALT
    mem[11] = 16'h8000;  // OUT R0 (must not run)
    release_rst();
    to_cycle(12); chk("halt_pc_c12", pc, 11);
    to_cycle(20); chk("halt_pc_c20", pc, 11);
    chk("halt_porta", porta, 4'hA);
    chk("halt_count_c20", dut.timer.tmr_reg[0], 3);
    to_cycle(21); chk("halt_count_c21", dut.timer.tmr_reg[0], 0);
    to_cycle(22); chk("halt_count_c22", dut.timer.tmr_reg[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pc", pc, 0);
    chk("async_porta", porta, 0);
    chk("async_tmr0", dut.timer.tmr_reg[0], 0);
    chk("async_tmr2", dut.timer.tmr_reg[2], 0);
    chk("async_tmr3", dut.timer.tmr_reg[3], 0);
    release_rst();
    to_cycle(1); chk("restart_pc", pc, 1);

`ifdef MINI_SOC_MATCH_FLAG_EN
    // ---------------- sticky match flag
    load_begin();
    mem[0] = 16'h1002;  // LDI R0,2
    mem[1] = 16'h9300;  // STT 3,R0
    mem[2] = 16'h1480;  // LDI R1,0x80
    mem[3] = 16'h9600;  // STT 2,R1
    mem[8] = 16'h9100;  // STT 1,R0 (clear flag)
    release_rst();
    to_cycle(7);  chk("flag_before", dut.timer.tmr_reg[1], 8'h00);
    to_cycle(8);  chk("flag_set", dut.timer.tmr_reg[1], 8'h01);
    to_cycle(10); chk("flag_cleared", dut.timer.tmr_reg[1], 8'h00);
    to_cycle(11); chk("flag_reset", dut.timer.tmr_reg[1], 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
